// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one non-pipelined single-operand FP unit among NUM_REQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module fp_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0]       req_a_stb,
  output logic [NUM_REQ-1:0]       req_a_ack,
  output logic [WIDTH-1:0]         rsp_z,
  output logic [NUM_REQ-1:0]       rsp_z_stb,
  input  logic [NUM_REQ-1:0]       rsp_z_ack,
  output logic [WIDTH-1:0]         unit_a,
  output logic                     unit_a_stb,
  input  logic                     unit_a_ack,
  input  logic [WIDTH-1:0]         unit_z,
  input  logic                     unit_z_stb,
  output logic                     unit_z_ack
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {ARB, ACCEPT, ISSUE, WAIT, DELIVER} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   last_grant_reg;
  logic [GW-1:0]   pick;
  logic [WIDTH-1:0] req_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_slice[gi] = req_a[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_a_stb[GW'(k)]) pick = GW'(k);
    end
  end
`else
  int idx;

  // Scan from farthest to nearest after last_grant so the nearest requester wins.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_a_stb[GW'(idx)]) pick = GW'(idx);
    end
  end
`endif

  // unit_a doubles as the captured operand and rsp_z as the captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      req_a_ack      <= '0;
      rsp_z_stb      <= '0;
      unit_a_stb     <= 1'b0;
      unit_z_ack     <= 1'b0;
      rsp_z          <= '0;
      unit_a         <= '0;
    end else begin
      case (state_reg)
        ARB: begin
          if (|req_a_stb) begin
            grant_reg <= pick;
            state_reg <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (req_a_ack[grant_reg]) begin
            req_a_ack <= '0;
            if (req_a_stb[grant_reg]) begin
              unit_a     <= req_slice[grant_reg];
              unit_a_stb <= 1'b1;
              state_reg  <= ISSUE;
            end else begin
              state_reg <= ARB;
            end
          end else if (req_a_stb[grant_reg]) begin
            req_a_ack[grant_reg] <= 1'b1;
          end else begin
            state_reg <= ARB;
          end
        end
        ISSUE: begin
          if (unit_a_ack) begin
            unit_a_stb <= 1'b0;
            unit_z_ack <= 1'b1;
            state_reg  <= WAIT;
          end
        end
        WAIT: begin
          if (unit_z_stb) begin
            unit_z_ack           <= 1'b0;
            rsp_z                <= unit_z;
            rsp_z_stb[grant_reg] <= 1'b1;
            state_reg            <= DELIVER;
          end
        end
        DELIVER: begin
          if (rsp_z_ack[grant_reg]) begin
            rsp_z_stb      <= '0;
            last_grant_reg <= grant_reg;
            state_reg      <= ARB;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter with a 20-cycle sqrt unit model, directed tables and random traffic.
module tb_fp_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*W-1:0] req_a;
  logic [N-1:0]   req_a_stb, req_a_ack, rsp_z_stb, rsp_z_ack;
  logic [W-1:0]   rsp_z, unit_a, unit_z;
  logic           unit_a_stb, unit_a_ack, unit_z_stb, unit_z_ack;

  always #5 clk = ~clk;

  fp_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_a_stb(req_a_stb), .req_a_ack(req_a_ack),
    .rsp_z(rsp_z), .rsp_z_stb(rsp_z_stb), .rsp_z_ack(rsp_z_ack),
    .unit_a(unit_a), .unit_a_stb(unit_a_stb), .unit_a_ack(unit_a_ack),
    .unit_z(unit_z), .unit_z_stb(unit_z_stb), .unit_z_ack(unit_z_ack)
  );

  function automatic logic [31:0] int_to_f(input int unsigned n);
    int p;
    logic [31:0] m;
    p = 0;
    for (int b = 0; b < 32; b++) if (n[b]) p = b;
    m = n << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] f_sqrt(input logic [31:0] a);
    logic [63:0] d, rb;
    real r;
    if (a[30:23] == 8'd0) return 32'd0;
    d  = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
    r  = $sqrt($bitstoreal(d));
    rb = $realtobits(r);
    return {rb[63], 8'(int'(rb[62:52]) - 896), rb[51:29]};
  endfunction

  // Shared unit: accepts when idle, answers 20 cycles later.
  int ust = 0;
  int ucnt = 0;
  logic [31:0] ua;
  assign unit_a_ack = (ust == 0);
  always @(posedge clk) begin
    if (rst) begin
      ust <= 0; unit_z_stb <= 1'b0; unit_z <= '0;
    end else begin
      case (ust)
        0: if (unit_a_stb) begin ua <= unit_a; ucnt <= 20; ust <= 1; end
        1: if (ucnt == 1) begin unit_z <= f_sqrt(ua); unit_z_stb <= 1'b1; ust <= 2; end
           else ucnt <= ucnt - 1;
        default: if (unit_z_ack) begin unit_z_stb <= 1'b0; ust <= 0; end
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int stray_cnt = 0;
  int cur_grant = 0;
  int model_last = N - 1;
  int grant_q[$];
  logic [N-1:0] watch, prev_ack, snap;
  logic [31:0] cur_op [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit skipped(input int j, input int g);
`ifdef ARB_FIXED_PRIO_EN
    return j < g;
`else
    return ((j - model_last - 1 + 2*N) % N) < ((g - model_last - 1 + 2*N) % N);
`endif
  endfunction

  task automatic monitor();
    logic [N-1:0] new_ack;
    forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0(req_a_ack) || !$onehot0(rsp_z_stb)) begin
        errors++;
        $display("FAIL onehot actual ack=%b stb=%b required at most one bit", req_a_ack, rsp_z_stb);
      end
      if (rst) begin
        model_last = N - 1; snap = '0; prev_ack = '0;
        continue;
      end
      if (((req_a_ack | rsp_z_stb) & ~watch) != '0) stray_cnt++;
      new_ack  = req_a_ack & ~prev_ack;
      prev_ack = req_a_ack;
      for (int g = 0; g < N; g++) begin
        if (new_ack[g]) begin
          grant_q.push_back(g);
          cur_grant = g;
          check($sformatf("grant_stb_r%0d", g), 32'(req_a_stb[g]), 32'd1);
          for (int j = 0; j < N; j++) begin
            if (j != g && snap[j] && req_a_stb[j] && skipped(j, g)) begin
              errors++;
              $display("FAIL order actual grant=%0d required grant=%0d first", g, j);
            end
          end
        end
      end
      if (unit_a_stb && unit_a_ack) begin
        issue_cnt++;
        check("unit_a", unit_a, cur_op[cur_grant]);
      end
      for (int g = 0; g < N; g++) begin
        if (rsp_z_stb[g] && rsp_z_ack[g]) begin
          snap = req_a_stb;
          model_last = g;
        end
      end
    end
  endtask

  task automatic req_op(input int i, input logic [31:0] a, input logic [31:0] exp, input int hold);
    int t;
    logic [31:0] got;
    cur_op[i] = a;
    req_a[i*W +: W] = a;
    req_a_stb[i] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_a_ack[i] && t < TMO);
    if (!req_a_ack[i]) begin
      check($sformatf("ack_timeout_r%0d", i), 32'(req_a_ack[i]), 32'd1);
      req_a_stb[i] = 1'b0;
      return;
    end
    @(posedge clk); #1 req_a_stb[i] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_z_stb[i] && t < TMO);
    if (!rsp_z_stb[i]) begin
      check($sformatf("rsp_timeout_r%0d", i), 32'(rsp_z_stb[i]), 32'd1);
      return;
    end
    got = rsp_z;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_z", rsp_z, got);
      check("hold_rsp_stb", 32'(rsp_z_stb[i]), 32'd1);
      check("hold_no_grant", 32'(req_a_ack), 32'd0);
    end
    check($sformatf("result_r%0d", i), got, exp);
    @(posedge clk); #1 rsp_z_ack[i] = 1'b1;
    @(posedge clk); #1 rsp_z_ack[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_a_ack"}, 32'(req_a_ack), 32'd0);
    check({tag, "_rsp_z_stb"}, 32'(rsp_z_stb), 32'd0);
    check({tag, "_unit_a_stb"}, 32'(unit_a_stb), 32'd0);
    check({tag, "_unit_z_ack"}, 32'(unit_z_ack), 32'd0);
    check({tag, "_rsp_z"}, rsp_z, 32'd0);
    check({tag, "_unit_a"}, unit_a, 32'd0);
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, "_count"}, 32'(grant_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < grant_q.size(); k++)
      check($sformatf("%s_grant%0d", tag, k), 32'(grant_q[k]), 32'(exp_q[k]));
  endtask

  task automatic rand_driver(input int i, input int ops);
    int unsigned n;
    for (int k = 0; k < ops; k++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      n = $urandom_range(1, 1000);
      req_op(i, int_to_f(n * n), int_to_f(n), $urandom_range(0, 3));
    end
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] z;
  } vec_t;

  vec_t tbl[5];
  int i0, s0, t;

  initial begin
    tbl[0] = '{2, 32'h41800000, 32'h40800000};
    tbl[1] = '{0, 32'h40800000, 32'h40000000};
    tbl[2] = '{1, 32'h41100000, 32'h40400000};
    tbl[3] = '{3, 32'h41C80000, 32'h40A00000};
    tbl[4] = '{1, 32'h3F800000, 32'h3F800000};
    req_a = '0; req_a_stb = '0; rsp_z_ack = '0; watch = '1;
    prev_ack = '0; snap = '0;
    for (int k = 0; k < N; k++) cur_op[k] = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Single operations, each on its own: one issue, no activity on other bits.
    for (int k = 0; k < 5; k++) begin
      i0 = issue_cnt; s0 = stray_cnt;
      watch = N'(1) << tbl[k].r;
      req_op(tbl[k].r, tbl[k].a, tbl[k].z, 0);
      watch = '1;
      check($sformatf("issue_once_v%0d", k), 32'(issue_cnt - i0), 32'd1);
      check($sformatf("stray_v%0d", k), 32'(stray_cnt - s0), 32'd0);
    end

`ifndef ARB_FIXED_PRIO_EN
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    grant_q.delete();
    fork
      req_op(0, 32'h40800000, 32'h40000000, 0);
      req_op(1, 32'h41100000, 32'h40400000, 0);
      req_op(2, 32'h41800000, 32'h40800000, 0);
      req_op(3, 32'h41C80000, 32'h40A00000, 0);
    join
    check_order("rr", '{0, 1, 2, 3});

    req_op(2, 32'h41800000, 32'h40800000, 0);
    grant_q.delete();
    fork
      req_op(1, 32'h41100000, 32'h40400000, 0);
      req_op(3, 32'h41C80000, 32'h40A00000, 0);
    join
    check_order("wrap", '{3, 1});
`else
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    grant_q.delete();
    fork
      for (int k = 0; k < 5; k++) req_op(0, 32'h41100000, 32'h40400000, 0);
      req_op(2, 32'h41800000, 32'h40800000, 0);
    join
    check_order("fixed", '{0, 0, 0, 0, 0, 2});
`endif

    // Backpressure on requester 0 while requester 1 waits.
    grant_q.delete();
    fork
      req_op(0, 32'h42100000, 32'h40C00000, 10);
      begin
        repeat (3) @(posedge clk);
        #1 req_op(1, 32'h42440000, 32'h40E00000, 0);
      end
    join
    check_order("bp", '{0, 1});

    // Reset while the operation sits in the unit.
    cur_op[3] = 32'h42000000;
    req_a[3*W +: W] = 32'h42000000;
    req_a_stb[3] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_a_ack[3] && t < TMO);
    check("mid_ack", 32'(req_a_ack[3]), 32'd1);
    @(posedge clk); #1 req_a_stb[3] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (unit_a_stb && t < TMO);
    check("mid_issued", 32'(unit_a_stb), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    grant_q.delete();
    req_op(3, 32'h42C80000, 32'h41200000, 0);
    check_order("after_rst", '{3});

    fork
      rand_driver(0, 8);
      rand_driver(1, 8);
      rand_driver(2, 8);
      rand_driver(3, 8);
    join

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
